// File: rtl/uart_rx_deser_if.sv
// rtl/uart_rx_deser_if.sv - character stream from the UART receive deserializer
// The master drives the held character and its flags; the slave returns ready.
interface uart_rx_deser_if;
  logic [7:0] rx_data_o;
  logic       rx_parity_err_o;
  logic       rx_frame_err_o;
  logic       rx_valid_o;
  logic       rx_ready_i;

  modport master (
    output rx_data_o,
    output rx_parity_err_o,
    output rx_frame_err_o,
    output rx_valid_o,
    input  rx_ready_i
  );

  modport slave (
    input  rx_data_o,
    input  rx_parity_err_o,
    input  rx_frame_err_o,
    input  rx_valid_o,
    output rx_ready_i
  );
endinterface

// File: rtl/uart_rx_deser.sv
// rtl/uart_rx_deser.sv - oversampling UART receive deserializer with one-entry holding register
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around the bit centre instead of a single sample.
module uart_rx_deser #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   rx_i,
  input  logic [15:0]            cfg_div_i,
  input  logic [1:0]             cfg_bits_i,
  input  logic                   cfg_parity_en_i,
  input  logic                   cfg_even_parity_i,
  uart_rx_deser_if.master        rx,
  output logic                   overrun_o,
  output logic                   busy_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   rxs_d1;
  logic [15:0]            div_q;
  logic [15:0]            cnt;
  logic [1:0]             bits_q;
  logic                   par_en_q;
  logic                   even_q;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   par_acc;
  logic                   frame_perr;
  logic [7:0]             data_q;
  logic                   perr_q;
  logic                   ferr_q;
  logic                   valid_q;
  logic                   overrun_q;
  logic                   busy_q;
  logic [15:0]            mid;
  logic                   samp_hit;
  logic                   samp_val;
  logic                   wrap;
  logic [7:0]             frame_data;

  assign rxs  = sync_q[SYNC_STAGES-1];
  assign mid  = div_q >> 1;
  assign wrap = (cnt == div_q);

`ifdef UART_RX_MAJORITY_EN
  logic rxs_d2;

  always_ff @(posedge CLK) begin
    if (!RSTN) rxs_d2 <= 1'b1;
    else       rxs_d2 <= rxs_d1;
  end

  // rxs_d2/rxs_d1/rxs hold the line at cnt = M-1, M, M+1 when cnt reaches M+1
  assign samp_hit = (cnt == mid + 16'd1);
  assign samp_val = (rxs & rxs_d1) | (rxs & rxs_d2) | (rxs_d1 & rxs_d2);
`else
  assign samp_hit = (cnt == mid);
  assign samp_val = rxs;
`endif

  // Bits enter at the MSB, so a short character is right-aligned by shifting out the unused slots
  assign frame_data = shreg >> (2'd3 - bits_q);

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state      <= IDLE;
      sync_q     <= '1;
      rxs_d1     <= 1'b1;
      div_q      <= 16'd3;
      cnt        <= '0;
      bits_q     <= '0;
      par_en_q   <= 1'b0;
      even_q     <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      frame_perr <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rxs_d1    <= rxs;
      overrun_q <= 1'b0;

      if (valid_q && rx.rx_ready_i) valid_q <= 1'b0;

      if (state != IDLE && state != BREAK) cnt <= wrap ? '0 : cnt + 16'd1;

      case (state)
        IDLE: begin
          if (rxs_d1 && !rxs) begin
            div_q      <= (cfg_div_i < 16'd3) ? 16'd3 : cfg_div_i;
            bits_q     <= cfg_bits_i;
            par_en_q   <= cfg_parity_en_i;
            even_q     <= cfg_even_parity_i;
            cnt        <= '0;
            bit_cnt    <= '0;
            par_acc    <= 1'b0;
            frame_perr <= 1'b0;
            state      <= START;
            busy_q     <= 1'b1;
          end
        end
        START: begin
          if (samp_hit && samp_val) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (wrap) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (samp_hit) begin
            shreg   <= {samp_val, shreg[7:1]};
            par_acc <= par_acc ^ samp_val;
          end
          if (wrap) begin
            if (bit_cnt == {1'b1, bits_q}) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        PARITY: begin
          if (samp_hit) frame_perr <= par_acc ^ samp_val ^ ~even_q;
          if (wrap) state <= STOP;
        end
        STOP: begin
          if (samp_hit) begin
            if (!valid_q || rx.rx_ready_i) begin
              data_q  <= frame_data;
              perr_q  <= frame_perr;
              ferr_q  <= ~samp_val;
              valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
            // Leaving on the stop sample lets a start edge late in the stop bit be caught
            if (samp_val) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rxs) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx.rx_data_o       = data_q;
  assign rx.rx_parity_err_o = perr_q;
  assign rx.rx_frame_err_o  = ferr_q;
  assign rx.rx_valid_o      = valid_q;
  assign overrun_o          = overrun_q;
  assign busy_o             = busy_q;

endmodule

// File: doc/uart_rx_deser.md
# uart_rx_deser

Oversampling UART receive deserializer for the APB UART peripheral. It sits between the `rx_i` pad and the receive FIFO. It synchronizes and samples the serial line, recovers 5–8-bit frames with optional parity, and presents each character with per-character parity and framing flags on a valid/ready interface. A one-entry output holding register absorbs FIFO back-pressure and reports overruns.

## Interface
- `SYNC_STAGES`, default 2: number of flops in the `rx_i` synchronizer chain; minimum 2.
- `CLK` in 1: clock.
- `RSTN` in 1: reset, synchronous, active-low.
- `rx_i` in 1: asynchronous serial input; idle high.
- `cfg_div_i` in 16: bit period minus one. Bit period is P = `cfg_div_i` + 1 cycles; values below 3 are treated as 3.
- `cfg_bits_i` in 2: data bits = 5 + `cfg_bits_i`.
- `cfg_parity_en_i` in 1: a parity bit follows the data bits.
- `cfg_even_parity_i` in 1: 1 = even parity, 0 = odd parity.
- `rx_data_o` out 8: received character, LSB-first, zero-extended above the configured width.
- `rx_parity_err_o` out 1: parity mismatch for the character in `rx_data_o`.
- `rx_frame_err_o` out 1: stop bit sampled low for the character in `rx_data_o`.
- `rx_valid_o` out 1: holding register full.
- `rx_ready_i` in 1: consumer accepts the character.
- `overrun_o` out 1: one-cycle pulse when a completed frame is dropped.
- `busy_o` out 1: high in every state except IDLE.

## Operation
- The synchronizer flops reset to 1. The FSM state machine and the edge detector see only the synchronized line, `rxs`.
- States are IDLE, START, DATA, PARITY, STOP and BREAK.
- **IDLE:** a cycle with previous `rxs`=1 and current `rxs`=0 enters START. In that cycle the block latches all `cfg_*` inputs, clears the bit counter, and clears the cycle counter `cnt` to 0. Configuration changes mid-frame have no effect until the next start.
- **Sample point:** `cnt` counts 0..P-1, then wraps to 0 and advances the bit. The sample is taken at `cnt` == M, where M = `cfg_div_i` >> 1 (latched value).
- **START:** sample=1 is a false start; go to IDLE with no output. Sample=0 continues; at wrap go to DATA.
- **DATA:** shift the sample into the MSB-first shift register so the first bit ends as the LSB. After 5 + `cfg_bits` samples, go to PARITY if parity is enabled, otherwise STOP. Each transition occurs at the wrap of the last bit.
- **PARITY:** compute the error.
  - Even parity: error = XOR(data bits, parity bit) ≠ 0.
  - Odd parity: error = XOR(data bits, parity bit) ≠ 1.
  - Go to STOP at wrap.
- **STOP:** at the sample point, complete the frame and attempt the load. Stop sample=1 goes to IDLE in the same cycle, so a start edge in the second half of the stop bit is caught. Stop sample=0 sets `frame_err` and goes to BREAK.
- **BREAK:** wait for `rxs`=1, then go to IDLE. A held-low line yields exactly one character, 0x00 with `rx_frame_err_o`=1.
- **Load:**
  - If `rx_valid_o`=0, or `rx_valid_o`=1 and `rx_ready_i`=1 in the same cycle, the holding register takes the new data and flags, and `rx_valid_o`=1 next cycle.
  - Otherwise the new frame is discarded, the held data is unchanged, and `overrun_o`=1 for one cycle.
- **Handshake:** a transfer occurs on a cycle with `rx_valid_o`=1 and `rx_ready_i`=1. Without a simultaneous load, `rx_valid_o` drops next cycle. `rx_data_o` and the flags stay stable while valid is high and not accepted. `rx_valid_o` is never combinationally dependent on `rx_ready_i`.

## Timing
- Reset: state IDLE; `rx_data_o`=0x00; `rx_valid_o`, `rx_parity_err_o`, `rx_frame_err_o`, `overrun_o` and `busy_o` all 0; counters 0. A reset mid-frame aborts the frame with no output.
- Edge detection happens SYNC_STAGES + 1 cycles after the `rx_i` fall.
- `rx_valid_o` rises one cycle after the stop-bit sample cycle. That cycle is (1 + nbits + par)·P + M cycles after the START entry.
- Back-to-back frames at full rate are supported with zero idle bits.
- `busy_o` is registered and follows the state.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each bit value is the 2-of-3 majority of `rxs` at `cnt` = M-1, M and M+1. The decision is made at M+1, and all transitions reference the M+1 cycle, so latency grows by 1 cycle.
- `UART_RX_MAJORITY_EN` undefined: a single sample at `cnt` = M.

## Test plan
- `cfg_div_i`=15, 8N1, send 0xA5 then 0x3C back-to-back, `rx_ready_i`=1 → two valid pulses carrying 0xA5 and 0x3C, with both error flags 0.
- 7 bits, even parity, send 0x41 with parity bit 1 (wrong) → `rx_data_o`=0x41 and `rx_parity_err_o`=1. Same frame with odd parity selected → error 0.
- `rx_i` low for 4 cycles (P=16) → false start: no valid and `busy_o` back to 0. Line held low 12 bit times → one 0x00 character with `rx_frame_err_o`=1, then no further frames until the line goes high.
- `rx_ready_i`=0, send 0x11 then 0x22 → 0x11 is held and `overrun_o` pulses once at the 0x22 stop sample. Same sequence with `rx_ready_i` raised in the load cycle → 0x11 is consumed, 0x22 is loaded, and `rx_valid_o` stays 1.
- Assert `RSTN`=0 for 1 cycle during DATA of 0x5A, then release → all outputs 0 and no character delivered. A subsequent 0x5A is received correctly.
- Macro defined: a 1-cycle glitch at M in a data bit of 0xFF → received as 0xFF. Macro undefined → that bit reads 0.
